// File: rtl/acc_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_control_unit_pkg
// Description : Shared definitions for the 8-bit accumulator CPU: instruction
//               opcodes, ALU operation codes (also used by the alu) and the
//               sequencer state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_control_unit_pkg;

  // Instruction opcodes, IR[7:5]
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STA = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_JC  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  // ALU operation codes. The arithmetic opcodes equal their ALU codes, so
  // EXECUTE can forward IR[7:5] unchanged.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_LDA = 3'b010;

  // Sequencer state encodings
  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_OPERAND = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_STORE   = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/acc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : acc_control_unit
// Description : Fetch/decode/execute sequencer of the 8-bit accumulator CPU.
//               Initiator on the memory req/ack interface and on the ALU
//               interface; holds PC, IR, MDR, ACC and the Z/C flags.
// Ports       : clk_i, rst_i           - clock, synchronous active-high reset
//               mem_req_o/we_o/addr_o/wdata_o, mem_rdata_i/ack_i - memory
//               alu_x_o/y_o/op_o, alu_r_i/fz_i/fc_i              - ALU
//               acc_o, pc_o, flag_z_o, flag_c_o                  - state
//               retire_o (1-cycle pulse), halted_o               - status
// Revision    : 1.0 - initial release
// ============================================================================
module acc_control_unit
  import acc_control_unit_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,   // must satisfy 3 + ADDR_W == DATA_W
  parameter int PC_RESET = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [DATA_W-1:0] alu_x_o,
  output logic [DATA_W-1:0] alu_y_o,
  output logic [2:0]        alu_op_o,
  input  logic [DATA_W-1:0] alu_r_i,
  input  logic              alu_fz_i,
  input  logic              alu_fc_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              flag_z_o,
  output logic              flag_c_o,
  output logic              retire_o,
  output logic              halted_o
);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_acc;
  logic              r_z;
  logic              r_c;
  logic              r_retire;

  logic [2:0]        w_opcode;
  logic [ADDR_W-1:0] w_addr_field;
  logic              w_req;
  logic              w_ack;

  assign w_opcode     = r_ir[DATA_W-1 -: 3];
  assign w_addr_field = r_ir[ADDR_W-1:0];

  // Reset overrides the request combinationally so an access in flight is
  // withdrawn in the reset cycle; an ack seen then is treated as absent.
  assign mem_req_o = w_req & ~rst_i;
  assign w_ack     = mem_ack_i & mem_req_o;

  assign mem_wdata_o = r_acc;
  assign alu_x_o     = r_acc;
  assign alu_y_o     = r_mdr;
  assign acc_o       = r_acc;
  assign pc_o        = r_pc;
  assign flag_z_o    = r_z;
  assign flag_c_o    = r_c;
  assign retire_o    = r_retire;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:   if (w_ack) w_next_state = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          OP_ADD, OP_SUB, OP_LDA: w_next_state = S_OPERAND;
          OP_STA:                 w_next_state = S_STORE;
          OP_HLT:                 w_next_state = S_HALT;
          default:                w_next_state = S_FETCH;  // jumps
        endcase
      end
      S_OPERAND: if (w_ack) w_next_state = S_EXECUTE;
      S_EXECUTE: w_next_state = S_FETCH;
      S_STORE:   if (w_ack) w_next_state = S_FETCH;
      S_HALT:    w_next_state = S_HALT;
      default:   w_next_state = S_FETCH;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // Address and write-enable depend only on registered state, so they stay
  // stable for the whole of a waited access.
  always_comb begin
    w_req      = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = w_addr_field;
    alu_op_o   = ALU_ADD;
    halted_o   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req      = 1'b1;
        mem_addr_o = r_pc;
      end
      S_OPERAND: w_req = 1'b1;
      S_EXECUTE: alu_op_o = w_opcode;
      S_STORE: begin
        w_req    = 1'b1;
        mem_we_o = 1'b1;
      end
      S_HALT:    halted_o = 1'b1;
      default:   ;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc     <= ADDR_W'(PC_RESET);
      r_ir     <= '0;
      r_mdr    <= '0;
      r_acc    <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_retire <= 1'b0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (w_ack) begin
            r_ir <= mem_rdata_i;
            r_pc <= r_pc + ADDR_W'(1);  // wraps modulo 2^ADDR_W
          end
        end
        S_DECODE: begin
          case (w_opcode)
            OP_JMP: begin
              r_pc     <= w_addr_field;
              r_retire <= 1'b1;
            end
            OP_JZ: begin
              if (r_z) r_pc <= w_addr_field;
              r_retire <= 1'b1;
            end
            OP_JC: begin
              if (r_c) r_pc <= w_addr_field;
              r_retire <= 1'b1;
            end
            OP_HLT:  r_retire <= 1'b1;
            default: ;
          endcase
        end
        S_OPERAND: if (w_ack) r_mdr <= mem_rdata_i;
        S_EXECUTE: begin
          r_acc    <= alu_r_i;
          r_z      <= alu_fz_i;
          r_c      <= alu_fc_i;
          r_retire <= 1'b1;
        end
        S_STORE:   if (w_ack) r_retire <= 1'b1;
        default:   ;
      endcase
    end
  end

endmodule
`default_nettype wire
